// File: rtl/spi_readout_slave.sv
// spi_readout_slave: mode-0 SPI slave that decodes a command byte and streams TDC buffer words on MISO.
// SPI pins are oversampled in the clk domain; SCLK edges become one-clk rise/fall pulses.
module spi_readout_slave #(
    parameter int             WORD_W   = 24,
    parameter int             CMD_W    = 8,
    parameter logic [CMD_W-1:0] CMD_READ = 8'hA5,
    parameter logic [CMD_W-1:0] CMD_STAT = 8'h5A,
    parameter int             SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SPI_SCLK,
    input  logic              SPI_CSN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              SPI_MISO_OE,
    input  logic [WORD_W-1:0] IN_DATA,
    input  logic              INT,
    input  logic              read_done,
    output logic              SPI_Odstart,
    output logic              read_en,
    output logic [5:0]        word_cnt
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {IDLE, CMD, DATA, STAT, IGNORE} state_t;

    state_t              state_q, state_d;
    logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STG-1:0] csn_sync_q, csn_sync_d;
    logic [SYNC_STG-1:0] mosi_sync_q, mosi_sync_d;
    logic                sclk_prev_q, sclk_prev_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CMD_W-1:0]    cmd_reg_q, cmd_reg_d;
    logic [5:0]          word_cnt_q, word_cnt_d;
    logic [7:0]          snap_q, snap_d;
    logic                odstart_q, odstart_d;

    logic             sclk_s, csn_s, mosi_s, rise, fall, load;
    logic [CMD_W-1:0] cmd_next;

    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STG-1];
        csn_s       = csn_sync_q[SYNC_STG-1];
        mosi_s      = mosi_sync_q[SYNC_STG-1];
        rise        = sclk_s & ~sclk_prev_q;
        fall        = ~sclk_s & sclk_prev_q;
        cmd_next    = {cmd_reg_q[CMD_W-2:0], mosi_s};
        // bit_cnt parks at WORD_W once a word is fully clocked, so the next fall is a load
        load        = fall && bit_cnt_q == CNT_W'(WORD_W);
        sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], SPI_SCLK};
        csn_sync_d  = {csn_sync_q[SYNC_STG-2:0], SPI_CSN};
        mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], SPI_MOSI};
        sclk_prev_d = sclk_s;
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_reg_d   = cmd_reg_q;
        word_cnt_d  = word_cnt_q;
        snap_d      = snap_q;
        odstart_d   = 1'b0;
        if (csn_s) begin
            state_d   = IDLE;
            shreg_d   = '0;
            bit_cnt_d = '0;
            cmd_reg_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = CMD;
                CMD: if (rise) begin
                    cmd_reg_d = cmd_next;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                        bit_cnt_d = CNT_W'(WORD_W);
                        shreg_d   = '0;
                        snap_d    = {INT, read_done, word_cnt_q};
                        state_d   = cmd_next == CMD_READ ? DATA :
                                    cmd_next == CMD_STAT ? STAT : IGNORE;
                        if (cmd_next == CMD_READ) word_cnt_d = '0;
                    end
                end
                DATA, STAT: begin
                    if (rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (load) begin
                        bit_cnt_d = '0;
                        if (state_q == STAT) begin
                            shreg_d = {snap_q, {(WORD_W-8){1'b0}}};
                        end else if (INT && !read_done) begin
                            shreg_d    = IN_DATA;
                            odstart_d  = 1'b1;
                            word_cnt_d = word_cnt_q + {5'd0, ~&word_cnt_q};
                        end else begin
                            shreg_d = '0;
                        end
                    end else if (fall) begin
                        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            cmd_reg_q   <= '0;
            word_cnt_q  <= '0;
            snap_q      <= '0;
            odstart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            csn_sync_q  <= csn_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_reg_q   <= cmd_reg_d;
            word_cnt_q  <= word_cnt_d;
            snap_q      <= snap_d;
            odstart_q   <= odstart_d;
        end
    end

    assign SPI_MISO    = shreg_q[WORD_W-1];
    assign SPI_MISO_OE = ~csn_sync_q[SYNC_STG-1];
    assign read_en     = state_q == DATA;
    assign SPI_Odstart = odstart_q;
    assign word_cnt    = word_cnt_q;
endmodule

// File: tb/tb_spi_readout_slave.sv
// tb_spi_readout_slave: table-driven bursts against a two-word buffer model, plus abort and reset sequences.
module tb_spi_readout_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0, csn = 1'b1, mosi = 1'b0, int_v = 1'b0;
    logic        miso, miso_oe, odstart, read_en;
    logic [5:0]  word_cnt;
    logic [23:0] in_data;
    logic        read_done;

    int n_chk = 0, n_fail = 0;
    int n_strobe = 0, base = 0;

    always #5 clk = ~clk;

    spi_readout_slave dut (
        .clk(clk), .rst_n(rst_n), .SPI_SCLK(sclk), .SPI_CSN(csn), .SPI_MOSI(mosi),
        .SPI_MISO(miso), .SPI_MISO_OE(miso_oe), .IN_DATA(in_data), .INT(int_v),
        .read_done(read_done), .SPI_Odstart(odstart), .read_en(read_en), .word_cnt(word_cnt)
    );

    // buffer model: two words, advancing on each strobe, done after the second
    assign read_done = (n_strobe - base) >= 2;
    assign in_data   = (n_strobe - base) == 0 ? 24'h123456 :
                       (n_strobe - base) == 1 ? 24'hABCDEF : 24'h5A5A5A;

    task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) if (odstart) begin
        n_strobe++;
        chk("strobe_read_en", {71'd0, read_en}, 72'd1);
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] cmd);
        csn = 1'b0;
        half();
        for (int i = 7; i >= 0; i--) begin
            mosi = cmd[i];
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic read_bits(input int n, output logic [71:0] got, output logic rden);
        got  = '0;
        rden = 1'b0;
        for (int i = 0; i < n; i++) begin
            half();
            got = {got[70:0], miso};
            if (i == 0) rden = read_en;
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic end_burst();
        half();
        csn = 1'b1;
        half();
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic        int_v;
        logic [71:0] exp_w;
        int          exp_strobe;
        logic [5:0]  exp_cnt;
        logic        exp_rden;
    } vec_t;

    vec_t        vecs[6];
    logic [71:0] got;
    logic        rden;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 72'h123456_ABCDEF_000000, 2, 6'd2, 1'b1};
        vecs[1] = '{8'h5A, 1'b1, 72'h820000_820000_820000, 0, 6'd2, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 72'h0, 0, 6'd2, 1'b0};
        vecs[3] = '{8'hA5, 1'b0, 72'h0, 0, 6'd0, 1'b1};
        vecs[4] = '{8'h5A, 1'b1, 72'h800000_800000_800000, 0, 6'd0, 1'b0};
        vecs[5] = '{8'hA4, 1'b1, 72'h0, 0, 6'd0, 1'b0};

        // reset held while pins toggle
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            sclk = ~sclk; csn = ~csn; mosi = ~mosi;
            repeat (2) @(negedge clk);
            chk("rst_outs", {miso, miso_oe, odstart, read_en, word_cnt}, 72'd0);
        end
        sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_outs", {miso, miso_oe, odstart, read_en, word_cnt}, 72'd0);

        for (int v = 0; v < 6; v++) begin
            base  = n_strobe;
            int_v = vecs[v].int_v;
            send_cmd(vecs[v].cmd);
            read_bits(72, got, rden);
            end_burst();
            chk($sformatf("v%0d_words", v), got, vecs[v].exp_w);
            chk($sformatf("v%0d_strobes", v), 72'(n_strobe - base), 72'(vecs[v].exp_strobe));
            chk($sformatf("v%0d_word_cnt", v), {66'd0, word_cnt}, {66'd0, vecs[v].exp_cnt});
            chk($sformatf("v%0d_read_en", v), {71'd0, rden}, {71'd0, vecs[v].exp_rden});
            chk($sformatf("v%0d_oe_off", v), {70'd0, miso_oe, read_en}, 72'd0);
        end

        // CSN abort after 10 bits of the first word, then a fresh burst
        base  = n_strobe;
        int_v = 1'b1;
        send_cmd(8'hA5);
        read_bits(10, got, rden);
        chk("abort_bits", got, 72'h048);
        half();
        csn = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", {70'd0, miso_oe, read_en}, 72'd0);
        repeat (20) @(negedge clk);
        chk("abort_strobes", 72'(n_strobe - base), 72'd1);
        send_cmd(8'hA5);
        read_bits(24, got, rden);
        end_burst();
        chk("restart_word", got, 72'hABCDEF);
        chk("restart_strobes", 72'(n_strobe - base), 72'd2);
        chk("restart_cnt", {66'd0, word_cnt}, 72'd1);

        // asynchronous reset mid-burst
        base = n_strobe;
        send_cmd(8'hA5);
        read_bits(5, got, rden);
        half();
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {miso, miso_oe, odstart, read_en, word_cnt}, 72'd0);
        sclk = 1'b0; csn = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        base = n_strobe;
        send_cmd(8'hA5);
        read_bits(48, got, rden);
        end_burst();
        chk("postrst_words", got, 72'h123456_ABCDEF);
        chk("postrst_strobes", 72'(n_strobe - base), 72'd2);
        chk("postrst_cnt", {66'd0, word_cnt}, 72'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
